// File: rtl/reg_pkg.sv
// Shared definitions for the register-path blocks: FSM state encoding and a
// constant-evaluable clog2 helper used to size counters.
package reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;

    // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bit_counter_RTL.sv
// Bit counter with enable and synchronous clear; flags terminal count when the
// last data bit of a MAX_WIDTH-bit word is being presented.
module bit_counter_RTL
    import reg_pkg::*;
#(
    parameter int MAX_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic sclr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = clog2(MAX_WIDTH + 1);

    logic [CNT_W-1:0] bit_cnt;

    // Clear beats enable so a reload in the same cycle always restarts at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (sclr) begin
            bit_cnt <= '0;
        end else if (en) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    assign tc = (bit_cnt == CNT_W'(MAX_WIDTH - 1));

endmodule

// File: rtl/reg_piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready on both ports.
// Define REG_PISO_TX_PARITY_EN to append an even-parity bit after the data bits.
module reg_piso_tx
    import reg_pkg::*;
#(
    parameter int MAX_WIDTH = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclr,
    input  logic                 load_valid,
    input  logic [MAX_WIDTH-1:0] load_data,
    output logic                 load_ready,
    output logic                 ser_out,
    output logic                 ser_valid,
    input  logic                 ser_ready,
    output logic                 frame_start,
    output logic                 done
);

    state_t               state_q;
    state_t               state_d;
    logic [MAX_WIDTH-1:0] shift_q;
    logic [MAX_WIDTH-1:0] shift_d;
    logic [MAX_WIDTH-1:0] shifted;
    logic                 ser_out_q;
    logic                 ser_out_d;
    logic                 ser_valid_q;
    logic                 ser_valid_d;
    logic                 frame_start_q;
    logic                 frame_start_d;
    logic                 done_q;
    logic                 done_d;
    logic                 load_lead;
    logic                 shifted_lead;
    logic                 cnt_clr;
    logic                 cnt_en;
    logic                 last_bit;
`ifdef REG_PISO_TX_PARITY_EN
    logic                 parity_q;
    logic                 parity_d;
`endif

    // The outgoing bit always sits at the "lead" end, so shifting drains toward it.
    assign shifted      = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);
    assign load_lead    = (MSB_FIRST != 0) ? load_data[MAX_WIDTH-1] : load_data[0];
    assign shifted_lead = (MSB_FIRST != 0) ? shifted[MAX_WIDTH-1] : shifted[0];

    assign load_ready  = (state_q == ST_IDLE);
    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign done        = done_q;

    bit_counter_RTL #(
        .MAX_WIDTH(MAX_WIDTH)
    ) u_bit_counter (
        .clk (clk),
        .rst (rst),
        .sclr(cnt_clr),
        .en  (cnt_en),
        .tc  (last_bit)
    );

    // Next-state and next-output decode; the serial bit is precomputed so ser_out is a flop.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        ser_out_d     = ser_out_q;
        ser_valid_d   = ser_valid_q;
        frame_start_d = frame_start_q;
        done_d        = 1'b0;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;
`ifdef REG_PISO_TX_PARITY_EN
        parity_d      = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    state_d       = ST_SHIFT;
                    shift_d       = load_data;
                    ser_out_d     = load_lead;
                    ser_valid_d   = 1'b1;
                    frame_start_d = 1'b1;
                    cnt_clr       = 1'b1;
`ifdef REG_PISO_TX_PARITY_EN
                    parity_d      = ^load_data;
`endif
                end
            end

            ST_SHIFT: begin
                if (ser_ready) begin
                    shift_d       = shifted;
                    frame_start_d = 1'b0;
                    cnt_en        = 1'b1;
                    if (last_bit) begin
`ifdef REG_PISO_TX_PARITY_EN
                        state_d     = ST_PAR;
                        ser_out_d   = parity_q;
`else
                        state_d     = ST_IDLE;
                        ser_out_d   = 1'b0;
                        ser_valid_d = 1'b0;
                        done_d      = 1'b1;
`endif
                    end else begin
                        ser_out_d = shifted_lead;
                    end
                end
            end

`ifdef REG_PISO_TX_PARITY_EN
            ST_PAR: begin
                if (ser_ready) begin
                    state_d     = ST_IDLE;
                    ser_out_d   = 1'b0;
                    ser_valid_d = 1'b0;
                    done_d      = 1'b1;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Synchronous clear aborts any frame and suppresses the done pulse.
        if (sclr) begin
            state_d       = ST_IDLE;
            shift_d       = '0;
            ser_out_d     = 1'b0;
            ser_valid_d   = 1'b0;
            frame_start_d = 1'b0;
            done_d        = 1'b0;
            cnt_clr       = 1'b1;
            cnt_en        = 1'b0;
`ifdef REG_PISO_TX_PARITY_EN
            parity_d      = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            ser_out_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
`ifdef REG_PISO_TX_PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
            done_q        <= done_d;
`ifdef REG_PISO_TX_PARITY_EN
            parity_q      <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_reg_piso_tx.sv
// Scoreboard bench for reg_piso_tx: an MSB-first and an LSB-first instance share
// stimulus; expected bit streams are queued at load and checked by a negedge monitor.
module tb_reg_piso_tx;

    localparam int W = 8;
`ifdef REG_PISO_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    typedef struct packed {
        logic value;
        logic first;
        logic last;
    } exp_bit_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sclr = 1'b0;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_data = '0;
    logic         ser_ready = 1'b0;

    logic m_load_ready, m_ser_out, m_ser_valid, m_frame_start, m_done;
    logic l_load_ready, l_ser_out, l_ser_valid, l_frame_start, l_done;

    exp_bit_t q_msb[$];
    exp_bit_t q_lsb[$];
    bit       pend_done[2];
    int       checks = 0;
    int       errors = 0;

    reg_piso_tx #(.MAX_WIDTH(W), .MSB_FIRST(1)) u_dut_msb (
        .clk(clk), .rst(rst), .sclr(sclr),
        .load_valid(load_valid), .load_data(load_data), .load_ready(m_load_ready),
        .ser_out(m_ser_out), .ser_valid(m_ser_valid), .ser_ready(ser_ready),
        .frame_start(m_frame_start), .done(m_done)
    );

    reg_piso_tx #(.MAX_WIDTH(W), .MSB_FIRST(0)) u_dut_lsb (
        .clk(clk), .rst(rst), .sclr(sclr),
        .load_valid(load_valid), .load_data(load_data), .load_ready(l_load_ready),
        .ser_out(l_ser_out), .ser_valid(l_ser_valid), .ser_ready(ser_ready),
        .frame_start(l_frame_start), .done(l_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d actual=%0h expected=%0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    task automatic flushQueues();
        q_msb.delete();
        q_lsb.delete();
        pend_done[0] = 1'b0;
        pend_done[1] = 1'b0;
    endtask

    // Reference model: a frame is the data bits in transmit order, plus parity if built in.
    task automatic pushFrame(input logic [W-1:0] data);
        exp_bit_t e;
        for (int i = 0; i < W; i++) begin
            e.first = (i == 0);
            e.last  = (i == W - 1) && (PBITS == 0);
            e.value = data[W-1-i];
            q_msb.push_back(e);
            e.value = data[i];
            q_lsb.push_back(e);
        end
        if (PBITS != 0) begin
            e.first = 1'b0;
            e.last  = 1'b1;
            e.value = ^data;
            q_msb.push_back(e);
            q_lsb.push_back(e);
        end
    endtask

    task automatic checkOutput(input int idx, input logic so, input logic sv, input logic fs,
                               input logic dn, input logic lr);
        exp_bit_t e;
        bit have;
        have = (idx == 0) ? (q_msb.size() != 0) : (q_lsb.size() != 0);
        check("load_ready", idx, lr, !have);
        check("ser_valid", idx, sv, have);
        check("done", idx, dn, pend_done[idx]);
        pend_done[idx] = 1'b0;
        if (have) begin
            e = (idx == 0) ? q_msb[0] : q_lsb[0];
            check("ser_out", idx, so, e.value);
            check("frame_start", idx, fs, e.first);
            if (ser_ready) begin
                if (idx == 0) void'(q_msb.pop_front());
                else          void'(q_lsb.pop_front());
                if (e.last) pend_done[idx] = 1'b1;
            end
        end else begin
            check("idle_ser_out", idx, so, 1'b0);
            check("idle_frame_start", idx, fs, 1'b0);
        end
    endtask

    task automatic checkIdleNow(input string tag);
        check({tag, "_ser_out"}, 0, m_ser_out, 1'b0);
        check({tag, "_ser_valid"}, 0, m_ser_valid, 1'b0);
        check({tag, "_frame_start"}, 0, m_frame_start, 1'b0);
        check({tag, "_done"}, 0, m_done, 1'b0);
        check({tag, "_load_ready"}, 0, m_load_ready, 1'b1);
        check({tag, "_ser_out"}, 1, l_ser_out, 1'b0);
        check({tag, "_ser_valid"}, 1, l_ser_valid, 1'b0);
        check({tag, "_frame_start"}, 1, l_frame_start, 1'b0);
        check({tag, "_done"}, 1, l_done, 1'b0);
        check({tag, "_load_ready"}, 1, l_load_ready, 1'b1);
    endtask

    always @(negedge clk) begin
        checkOutput(0, m_ser_out, m_ser_valid, m_frame_start, m_done, m_load_ready);
        checkOutput(1, l_ser_out, l_ser_valid, l_frame_start, l_done, l_load_ready);
    end

    // mode 0: always ready; 1: stall cycles 3..5; 2: random ready.
    // abort 0: none; 1: sclr at abort_cyc; 2: async rst at abort_cyc.
    task automatic applyStimulus(input logic [W-1:0] data, input int mode, input int abort,
                                 input int abort_cyc, input int exp_len);
        int cyc;
        bit aborted;
        bit timed_out;
        load_valid = 1'b1;
        load_data  = data;
        ser_ready  = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        pushFrame(data);
        cyc       = 0;
        aborted   = 1'b0;
        timed_out = 1'b0;
        while ((q_msb.size() != 0 || q_lsb.size() != 0) && !timed_out) begin
            cyc++;
            case (mode)
                0:       ser_ready = 1'b1;
                1:       ser_ready = !(cyc >= 3 && cyc <= 5);
                default: ser_ready = ($urandom_range(0, 3) != 0);
            endcase
            load_valid = 1'($urandom_range(0, 1));
            load_data  = W'($urandom);
            if (abort == 1 && cyc == abort_cyc) begin
                sclr = 1'b1;
                @(posedge clk); #1;
                flushQueues();
                load_valid = 1'b1;
                load_data  = W'($urandom);
                @(posedge clk); #1;
                sclr       = 1'b0;
                load_valid = 1'b0;
                aborted    = 1'b1;
                break;
            end
            if (abort == 2 && cyc == abort_cyc) begin
                load_valid = 1'b1;
                #2;
                rst = 1'b1;
                flushQueues();
                #1;
                checkIdleNow("rst_async");
                @(posedge clk); #1;
                rst        = 1'b0;
                load_valid = 1'b0;
                aborted    = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (cyc > 100) timed_out = 1'b1;
        end
        load_valid = 1'b0;
        if (timed_out) begin
            check("frame_timeout", 0, 1, 0);
            flushQueues();
        end
        if (!aborted && !timed_out && exp_len != 0) check("frame_len", 0, cyc, exp_len);
    endtask

    initial begin
        pend_done[0] = 1'b0;
        pend_done[1] = 1'b0;
        #1 rst = 1'b1;
        #1 checkIdleNow("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        applyStimulus(8'hA5, 0, 0, 0, W + PBITS);
        applyStimulus(8'h01, 0, 0, 0, W + PBITS);
        applyStimulus(8'hF0, 1, 0, 0, W + PBITS + 3);
        applyStimulus(8'hFF, 0, 1, 4, 0);
        applyStimulus(8'h3C, 0, 0, 0, W + PBITS);
        applyStimulus(8'h96, 0, 2, 3, 0);
        applyStimulus(8'h07, 0, 0, 0, W + PBITS);
        applyStimulus(8'h00, 2, 0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            int pick;
            pick = $urandom_range(0, 19);
            if (pick == 0)      applyStimulus(W'($urandom), 2, 1, $urandom_range(1, W), 0);
            else if (pick == 1) applyStimulus(W'($urandom), 2, 2, $urandom_range(1, W), 0);
            else                applyStimulus(W'($urandom), 2, 0, 0, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
